// File: rtl/reset_sequencer.sv
// Board reset sequencer: holds the SoC in reset for a programmable number of
// ce ticks, waits for software to confirm boot, counts consecutive failed
// boots and latches a sticky recovery-boot request once too many pile up.
//
// CSR bus: csr_we is a single-cycle write strobe qualified by csr_a; there is
// no back-pressure, every write is accepted on the clk edge where csr_we=1.
// csr_do is a purely combinational read of the register selected by csr_a.
module reset_sequencer #(
  parameter logic [4:0] BASE_ADDR     = 5'h0,
  parameter logic [7:0] DFL_HOLD      = 8'h0f,
  parameter logic [3:0] MAX_RETRY     = 4'd3,
  parameter logic [7:0] BOOT_OK_VALUE = 8'ha5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       wdt_bite,
  output logic       soc_reset,
  output logic       boot_recovery,
  output logic       irq
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_BOOT = 2'b01,
    ST_RUN  = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] retry_q, retry_d;
  logic       boot_rec_q, boot_rec_d;
  logic [7:0] cause_q, cause_d;
  logic       bite_q;
  logic       irq_q, irq_d;

  // Address decode relative to the block base (5-bit wraparound)
  logic [4:0] off;
  logic       wr_ctrl, wr_hold, wr_bootok, wr_cause;
  logic       sw_req, clr_req, boot_ok, bite_ev;

  // Decoded write strobes and the watchdog rising-edge event
  always_comb begin
    off       = csr_a - BASE_ADDR;
    wr_ctrl   = csr_we && (off == 5'd0);
    wr_hold   = csr_we && (off == 5'd1);
    wr_bootok = csr_we && (off == 5'd2);
    wr_cause  = csr_we && (off == 5'd3);
    sw_req    = wr_ctrl && csr_di[7];
    clr_req   = wr_ctrl && csr_di[6];
    boot_ok   = wr_bootok && (csr_di == BOOT_OK_VALUE);
    bite_ev   = wdt_bite && !bite_q;
  end

  // FSM events consumed by the datapath
  logic       enter_hold;
  logic       retry_inc;
  logic       retry_zero;
  logic       cause_set;
  logic [7:0] cause_new;

  // State register; reset lands in HOLD so the SoC is held immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_HOLD;
    else     state_q <= state_d;
  end

  // Next-state logic; watchdog bites outrank software strobes and BOOT_OK
  always_comb begin
    state_d    = state_q;
    enter_hold = 1'b0;
    retry_inc  = 1'b0;
    retry_zero = 1'b0;
    cause_set  = 1'b0;
    cause_new  = 8'h00;
    unique case (state_q)
      ST_HOLD: begin
        if (ce && (hold_cnt_q == 8'd0)) state_d = ST_BOOT;
      end
      ST_BOOT: begin
        if (bite_ev) begin
          enter_hold = 1'b1;
          retry_inc  = 1'b1;
          cause_set  = 1'b1;
          cause_new  = 8'h02;
        end else if (sw_req) begin
          enter_hold = 1'b1;
          retry_inc  = 1'b1;
          cause_set  = 1'b1;
          cause_new  = 8'h04;
        end else if (boot_ok) begin
          retry_zero = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bite_ev) begin
          enter_hold = 1'b1;
          retry_inc  = 1'b1;
          cause_set  = 1'b1;
          cause_new  = 8'h02;
        end else if (sw_req) begin
          // A deliberate software reset from a running system is not a failed boot
          enter_hold = 1'b1;
          cause_set  = 1'b1;
          cause_new  = 8'h04;
        end
      end
      default: begin
        enter_hold = 1'b1;
      end
    endcase
    if (enter_hold) state_d = ST_HOLD;
  end

  // Output decode; soc_reset comes straight from the state register
  always_comb begin
    soc_reset = !((state_q == ST_BOOT) || (state_q == ST_RUN));
    unique case (off)
      5'd0:    csr_do = {state_q, 1'b0, boot_rec_q, retry_q};
      5'd1:    csr_do = hold_q;
      5'd3:    csr_do = cause_q;
      default: csr_do = 8'h00;
    endcase
  end

  assign boot_recovery = boot_rec_q;
  assign irq           = irq_q;

  // Datapath next values: the CTRL clear applies before any retry increment
  logic [3:0] retry_base;
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (enter_hold) begin
      hold_cnt_d = hold_q;
    end else if ((state_q == ST_HOLD) && ce && (hold_cnt_q != 8'd0)) begin
      hold_cnt_d = hold_cnt_q - 8'd1;
    end

    hold_d = wr_hold ? csr_di : hold_q;

    retry_base = clr_req ? 4'd0 : retry_q;
    retry_d    = retry_base;
    if (retry_zero) begin
      retry_d = 4'd0;
    end else if (retry_inc && (retry_base != 4'hf)) begin
      retry_d = retry_base + 4'd1;
    end

    boot_rec_d = (boot_rec_q && !clr_req) || (retry_inc && (retry_d >= MAX_RETRY));
    irq_d      = boot_rec_d && !boot_rec_q;

    // A new reset cause recorded on HOLD entry beats a simultaneous CAUSE clear
    cause_d = cause_q;
    if (wr_cause)  cause_d = 8'h00;
    if (cause_set) cause_d = cause_new;
  end

  // Datapath registers; bite_q resets high so a level held across reset is not an event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= DFL_HOLD;
      hold_q     <= DFL_HOLD;
      retry_q    <= 4'd0;
      boot_rec_q <= 1'b0;
      cause_q    <= 8'h01;
      bite_q     <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
      retry_q    <= retry_d;
      boot_rec_q <= boot_rec_d;
      cause_q    <= cause_d;
      bite_q     <= wdt_bite;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: table vectors, hand sequences for multi-cycle
// corners, then randomized traffic against a behavioural model.
module tb_reset_sequencer;

  localparam logic [4:0] BASE = 5'h0;
  localparam logic [7:0] DFL  = 8'h0f;
  localparam int         MAXR = 3;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'd0;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic       wdt_bite = 1'b0;
  logic       soc_reset;
  logic       boot_recovery;
  logic       irq;

  always #10 clk = ~clk;

  reset_sequencer #(
    .BASE_ADDR    (BASE),
    .DFL_HOLD     (DFL),
    .MAX_RETRY    (4'(MAXR)),
    .BOOT_OK_VALUE(8'ha5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .csr_a        (csr_a),
    .csr_di       (csr_di),
    .csr_we       (csr_we),
    .csr_do       (csr_do),
    .wdt_bite     (wdt_bite),
    .soc_reset    (soc_reset),
    .boot_recovery(boot_recovery),
    .irq          (irq)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard compare
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=hold,1=boot,2=run, ticks left before boot
  int         m_mode;
  int         m_left;
  logic [7:0] m_hold;
  int         m_retry;
  bit         m_rec;
  logic [7:0] m_cause;
  bit         m_irq;
  bit         m_prev_bite;

  task automatic model_reset();
    m_mode = 0; m_left = int'(DFL); m_hold = DFL; m_retry = 0;
    m_rec = 0; m_cause = 8'h01; m_irq = 0; m_prev_bite = 1;
  endtask

  function automatic logic [7:0] model_read(input logic [4:0] a);
    logic [4:0] o;
    logic [1:0] md;
    logic [3:0] rt;
    o  = a - BASE;
    md = 2'(m_mode);
    rt = 4'(m_retry);
    case (o)
      5'd0:    return {md, 1'b0, m_rec, rt};
      5'd1:    return m_hold;
      5'd3:    return m_cause;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input bit c, input bit w, input logic [4:0] a,
                            input logic [7:0] d, input bit b);
    logic [4:0] o;
    bit ev, sw, clr, ok, failed, to_hold, rec_before;
    int hold_at_edge;
    o = a - BASE;
    ev = b && !m_prev_bite;
    sw = w && (o == 5'd0) && d[7];
    clr = w && (o == 5'd0) && d[6];
    ok = w && (o == 5'd2) && (d == 8'ha5);
    failed = 0; to_hold = 0; rec_before = m_rec; hold_at_edge = int'(m_hold);
    if (clr) begin m_retry = 0; m_rec = 0; end
    if (w && o == 5'd3) m_cause = 8'h00;
    if (m_mode == 0) begin
      if (c) begin
        if (m_left == 0) m_mode = 1;
        else m_left--;
      end
    end else begin
      if (ev) begin failed = 1; m_cause = 8'h02; to_hold = 1; end
      else if (sw) begin failed = (m_mode == 1); m_cause = 8'h04; to_hold = 1; end
      else if (ok && m_mode == 1) begin m_retry = 0; m_mode = 2; end
    end
    if (failed) begin
      m_retry = (m_retry < 15) ? m_retry + 1 : 15;
      if (m_retry >= MAXR) m_rec = 1;
    end
    if (to_hold) begin m_mode = 0; m_left = hold_at_edge; end
    if (w && o == 5'd1) m_hold = d;
    m_irq = m_rec && !rec_before;
    m_prev_bite = b;
  endtask

  // Driver: one clock cycle, called just after a falling edge
  task automatic step(input bit c, input bit w, input logic [4:0] a,
                      input logic [7:0] d, input bit b);
    ce = c; csr_we = w; csr_a = a; csr_di = d; wdt_bite = b;
    #1;
    chk("csr_do", csr_do, model_read(a));
    @(posedge clk);
    model_step(c, w, a, d, b);
    @(negedge clk);
    chk("soc_reset", {7'b0, soc_reset}, {7'b0, (m_mode == 0)});
    chk("boot_recovery", {7'b0, boot_recovery}, {7'b0, m_rec});
    chk("irq", {7'b0, irq}, {7'b0, m_irq});
    ce = 0; csr_we = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string nm);
    csr_a = a; csr_we = 1'b0;
    #1;
    chk(nm, csr_do, exp);
  endtask

  typedef struct {
    bit         we;
    logic [4:0] a;
    logic [7:0] di;
    logic [4:0] ra;
    logic [7:0] exp_rd;
    bit         exp_soc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ticks;
    bit cev, rb, rw, rc;
    int k;
    logic [4:0] ra;
    logic [7:0] rdat;

    tbl[0]  = '{1'b1, 5'd2, 8'h5a, 5'd0,  8'h40, 1'b0};
    tbl[1]  = '{1'b1, 5'd2, 8'ha5, 5'd0,  8'h80, 1'b0};
    tbl[2]  = '{1'b1, 5'd2, 8'ha5, 5'd0,  8'h80, 1'b0};
    tbl[3]  = '{1'b1, 5'd1, 8'h00, 5'd1,  8'h00, 1'b0};
    tbl[4]  = '{1'b1, 5'd3, 8'hff, 5'd3,  8'h00, 1'b0};
    tbl[5]  = '{1'b1, 5'd0, 8'h3f, 5'd0,  8'h80, 1'b0};
    tbl[6]  = '{1'b0, 5'd4, 8'h00, 5'd4,  8'h00, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 8'h00, 5'd2,  8'h00, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 8'h00, 5'd31, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 5'd0, 8'h80, 5'd3,  8'h04, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 8'h00, 5'd0,  8'h00, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_soc", {7'b0, soc_reset}, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    rd(5'd0, 8'h00, "rst_ctrl");
    rd(5'd1, 8'h0f, "rst_hold");
    rd(5'd3, 8'h01, "rst_cause");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Hold lasts HOLD+1 ce ticks with ce every 4 clocks
    ticks = 0;
    for (int i = 0; i < 100 && soc_reset; i++) begin
      cev = (i % 4 == 3);
      step(cev, 0, 5'd0, 8'd0, 0);
      if (cev) ticks++;
    end
    chk("hold_ticks", 8'(ticks), 8'd16);
    chk("boot_soc", {7'b0, soc_reset}, 8'h00);
    rd(5'd0, 8'h40, "boot_ctrl");
    rd(5'd3, 8'h01, "boot_cause");

    // Table of single-cycle register accesses starting in BOOT
    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].we, tbl[i].a, tbl[i].di, 0);
      rd(tbl[i].ra, tbl[i].exp_rd, $sformatf("tbl%0d_rd", i));
      chk($sformatf("tbl%0d_soc", i), {7'b0, soc_reset}, {7'b0, tbl[i].exp_soc});
    end
    // HOLD=0 means one ce tick of reset
    step(0, 0, 5'd0, 8'd0, 0);
    chk("hold0_wait", {7'b0, soc_reset}, 8'h01);
    step(1, 0, 5'd0, 8'd0, 0);
    chk("hold0_rel", {7'b0, soc_reset}, 8'h00);
    rd(5'd0, 8'h40, "hold0_ctrl");

    // Three watchdog bites, each after BOOT is reached
    for (int kk = 1; kk <= 3; kk++) begin
      step(0, 0, 5'd0, 8'd0, 1);
      rd(5'd0, (kk == 3) ? 8'h13 : 8'(kk), $sformatf("bite%0d_ctrl", kk));
      chk($sformatf("bite%0d_irq", kk), {7'b0, irq}, (kk == 3) ? 8'h01 : 8'h00);
      chk($sformatf("bite%0d_soc", kk), {7'b0, soc_reset}, 8'h01);
      step(1, 0, 5'd0, 8'd0, 0);
      chk($sformatf("bite%0d_irq_end", kk), {7'b0, irq}, 8'h00);
    end
    rd(5'd3, 8'h02, "bite_cause");

    // Bite and BOOT_OK together: bite wins; then clear via CTRL bit6
    step(0, 1, 5'd2, 8'ha5, 1);
    rd(5'd0, 8'h14, "prio_ctrl");
    chk("prio_irq", {7'b0, irq}, 8'h00);
    step(0, 1, 5'd0, 8'h40, 1);
    rd(5'd0, 8'h00, "clr_ctrl");
    chk("clr_rec", {7'b0, boot_recovery}, 8'h00);
    chk("clr_irq", {7'b0, irq}, 8'h00);

    // Async reset in RUN
    step(0, 1, 5'd1, 8'h20, 0);
    step(1, 0, 5'd0, 8'd0, 0);
    step(0, 1, 5'd2, 8'ha5, 0);
    rd(5'd0, 8'h80, "run_ctrl");
    rst = 1'b1;
    wdt_bite = 1'b1;
    #1;
    chk("arst_run_soc", {7'b0, soc_reset}, 8'h01);
    rd(5'd0, 8'h00, "arst_run_ctrl");
    rd(5'd3, 8'h01, "arst_run_cause");
    rd(5'd1, 8'h0f, "arst_run_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Bite level held across release: no event all the way into BOOT
    for (int i = 0; i < 16; i++) step(1, 0, 5'd0, 8'd0, 1);
    rd(5'd0, 8'h40, "nobite_ctrl");
    rd(5'd3, 8'h01, "nobite_cause");
    // Clear plus sw strobe together in BOOT
    step(0, 1, 5'd0, 8'hc0, 1);
    rd(5'd0, 8'h01, "clrsw_ctrl");
    rd(5'd3, 8'h04, "clrsw_cause");
    // Async reset mid-HOLD
    step(1, 0, 5'd0, 8'd0, 0);
    step(1, 0, 5'd0, 8'd0, 0);
    rst = 1'b1;
    #1;
    chk("arst_hold_soc", {7'b0, soc_reset}, 8'h01);
    chk("arst_hold_rec", {7'b0, boot_recovery}, 8'h00);
    rd(5'd0, 8'h00, "arst_hold_ctrl");
    rd(5'd3, 8'h01, "arst_hold_cause");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model
    rb = 0;
    for (int i = 0; i < 3000; i++) begin
      rc = ($urandom_range(0, 2) == 0);
      rw = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) rb = !rb;
      k = $urandom_range(0, 9);
      if (k < 3)      ra = BASE + 5'd0;
      else if (k < 5) ra = BASE + 5'd1;
      else if (k < 8) ra = BASE + 5'd2;
      else if (k == 8) ra = BASE + 5'd3;
      else            ra = 5'($urandom_range(0, 31));
      case (k)
        0, 1, 2: rdat = {($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 6'($urandom)};
        3, 4:    rdat = 8'($urandom_range(0, 4));
        5, 6, 7: rdat = ($urandom_range(0, 1) == 1) ? 8'ha5 : 8'($urandom);
        default: rdat = 8'($urandom);
      endcase
      step(rc, rw, ra, rdat, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
